sprite_anim_render: RTL and testbench
=====================================

# sprite_anim_render

Parametrised, pipelined sprite renderer for the VGA end-of-game screens (victory/defeat banners, animated ship). It compares the VGA scan counters against a tear-free, frame-latched sprite position. It draws a scaled W×H bitmap in a configurable colour, alternating between two animation frames. A start/stop state machine sequences the show, then a blinking phase. RGB outputs feed the screen mux ahead of the VGA DAC.

## Interface
- SCALE, 6, integer pixel replication factor (≥1)
- SPR_W, 11, sprite width in source pixels
- SPR_H, 11, sprite height in source pixels
- PATTERN_A, all-zero, SPR_W*SPR_H-bit bitmap, frame A; bit index = y*SPR_W + x, 1 = lit
- PATTERN_B, all-zero, same format, frame B
- COLOR, 24'hFFFFFF, lit-pixel colour {R,G,B}
- V_ACTIVE, 480, first non-visible line (frame tick line)
- ANIM_FRAMES, 15, frames per animation pattern swap (≥1)
- HOLD_FRAMES, 120, frames in SHOW before entering BLINK (≥1)
- BLINK_FRAMES, 20, frames per visibility toggle in BLINK (≥1)
- clk  in  1  pixel clock, one pixel per cycle
- reset  in  1  asynchronous, active-low (0 = reset)
- h_counter  in  10  current horizontal pixel
- v_counter  in  10  current line
- POS_X  in  10  requested sprite top-left x
- POS_Y  in  10  requested sprite top-left y
- start  in  1  one-cycle request to begin the sequence
- stop  in  1  one-cycle request to end the sequence
- R, G, B  out  8 each  pixel colour, registered
- busy  out  1  registered; high when state ≠ IDLE

## Operation
- The frame tick is one cycle, registered internally, with h_counter==0 && v_counter==V_ACTIVE.
- At each frame tick, px/py latch POS_X/POS_Y. Position never changes mid-frame.
- States:
  - IDLE: sprite not drawn.
  - SHOW: sprite drawn continuously.
  - BLINK: sprite drawn only while vis=1.
- IDLE→SHOW: start=1 and stop=0. Clears frame_cnt, anim_cnt and anim_sel, and sets vis=1.
- SHOW→BLINK: at the frame tick where frame_cnt reaches HOLD_FRAMES-1. Clears frame_cnt.
- BLINK: at each frame tick, frame_cnt increments. On reaching BLINK_FRAMES-1, vis toggles and frame_cnt clears.
- Any state→IDLE: stop=1. Stop wins over a simultaneous start.
- start while not IDLE is ignored. The sequence does not restart.
- Animation: in SHOW and BLINK, anim_cnt counts frame ticks. At ANIM_FRAMES-1, anim_sel toggles (0=A, 1=B) and anim_cnt clears.
- Drawing window: dx=h_counter-px and dy=v_counter-py, both 11-bit zero-extended.
  - In box when h_counter≥px, dx<SPR_W*SCALE, v_counter≥py and dy<SPR_H*SCALE.
  - Comparisons are 11-bit so px+SPR_W*SCALE>1023 cannot wrap.
  - A sprite partly off the 640×480 area is clipped naturally.
- Source coordinates: sx=dx/SCALE, sy=dy/SCALE. Division is by a constant; no sequential divider.
- Lit pixel: in box, drawing enabled, and bit sy*SPR_W+sx of the selected pattern is 1. Lit → {R,G,B}=COLOR, else 0.

## Timing
- Reset (asynchronous, reset=0) values:
  - state IDLE, busy 0
  - R=G=B=0
  - px=py=0
  - frame_cnt, anim_cnt, anim_sel = 0; vis=1
  - all pipeline registers 0
- Pipeline latency is 2 clocks from h/v_counter to RGB:
  - Stage 1 registers in-box, dx and dy.
  - Stage 2 registers the pattern lookup and colour.
- busy rises 1 cycle after the start cycle and falls 1 cycle after the stop cycle.
- Draw enable is sampled at stage 1. Pixels already in stage 2 when stop is seen complete unchanged. RGB is all zero from stop+3.
- State, anim_sel and vis change only at frame ticks, except start/stop.
- Asserting reset mid-frame clears outputs immediately, without waiting for the clock. After release, the first sprite needs a start, then the next frame tick for a valid position.
- Release of reset is synchronised by the top level; no internal synchroniser.

## Test plan
- Reset: drive reset=0 mid-run with state in BLINK → R=G=B=0, busy=0 asynchronously; after release no drawing without start.
- Basic draw: SCALE=6, PATTERN_A = full row 5 only, POS=(100,50), start, one frame tick.
  - Required: pixel (100..165, 80..85) → FFFFFF at 2-cycle latency.
  - Required: (100,79) → 0 and (166,80) → 0.
- Tear-free move: change POS_X 100→200 mid-frame → the current frame still draws at x=100; the next frame draws at x=200.
- Animation and sequencing:
  - Setup: ANIM_FRAMES=2, HOLD_FRAMES=4, BLINK_FRAMES=2, distinct A/B patterns.
  - Required: pattern alternates every 2 frames.
  - Required: BLINK entered after 4 frames; visibility toggles every 2 frames.
- Start/stop edge cases:
  - start+stop in the same cycle → stays IDLE.
  - start during SHOW → hold count unaffected.
  - stop mid-line → RGB zero from stop+3 cycles.
- Clipping: POS=(1000,470), SCALE=6 → no wrap-around lit pixels at x<66 or y<56; only in-range pixels drawn.

Source files
------------

// File: rtl/sprite_anim_render.sv
// sprite_anim_render
// Draws a scaled two-frame animated sprite for the end-of-game screens.
// The sprite position is latched once per frame so it never tears, and a
// small IDLE/SHOW/BLINK sequencer gates drawing. Pixel path is two stages:
// stage 1 computes the in-box test and offsets, stage 2 looks the bit up in
// the selected pattern and registers the colour.
//
// Request semantics: start and stop are single-cycle pulses sampled on the
// rising clock edge; there is no ready/acknowledge. stop always wins over a
// simultaneous start, and start outside IDLE is dropped.

module sprite_anim_render #(
   parameter int                         SCALE        = 6,
   parameter int                         SPR_W        = 11,
   parameter int                         SPR_H        = 11,
   parameter logic [SPR_W*SPR_H-1:0]     PATTERN_A    = '0,
   parameter logic [SPR_W*SPR_H-1:0]     PATTERN_B    = '0,
   parameter logic [23:0]                COLOR        = 24'hFFFFFF,
   parameter int                         V_ACTIVE     = 480,
   parameter int                         ANIM_FRAMES  = 15,
   parameter int                         HOLD_FRAMES  = 120,
   parameter int                         BLINK_FRAMES = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] h_counter,
   input  logic [9:0] v_counter,
   input  logic [9:0] POS_X,
   input  logic [9:0] POS_Y,
   input  logic       start,
   input  logic       stop,
   output logic [7:0] R,
   output logic [7:0] G,
   output logic [7:0] B,
   output logic       busy,
   output logic [1:0] state_dbg
);

   localparam int NPIX   = SPR_W * SPR_H;
   localparam int IDX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int FC_MAX = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
   localparam int FC_W   = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;
   localparam int AC_W   = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

   // Box extents in screen pixels; 11 bits so px + extent cannot wrap.
   localparam logic [10:0]     BOX_W      = 11'(SPR_W * SCALE);
   localparam logic [10:0]     BOX_H      = 11'(SPR_H * SCALE);
   localparam logic [10:0]     SCALE_V    = 11'(SCALE);
   localparam logic [9:0]      V_TICK     = 10'(V_ACTIVE);
   localparam logic [FC_W-1:0] HOLD_LAST  = FC_W'(HOLD_FRAMES - 1);
   localparam logic [FC_W-1:0] BLINK_LAST = FC_W'(BLINK_FRAMES - 1);
   localparam logic [AC_W-1:0] ANIM_LAST  = AC_W'(ANIM_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLINK = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              busy_d;
   logic              draw_en;

   logic              tick_q;
   logic [9:0]        px_q;
   logic [9:0]        py_q;
   logic [FC_W-1:0]   frame_cnt_q;
   logic [AC_W-1:0]   anim_cnt_q;
   logic              anim_sel_q;
   logic              vis_q;

   logic [10:0]       dx;
   logic [10:0]       dy;
   logic              in_box;
   logic              s1_hit_q;
   logic [10:0]       s1_dx_q;
   logic [10:0]       s1_dy_q;

   logic [10:0]       sx;
   logic [10:0]       sy;
   logic [IDX_W-1:0]  pix_idx;
   logic [NPIX-1:0]   pattern;
   logic              lit;

   assign state_dbg = state_q;

   // Frame tick: one cycle, registered, when the scan reaches the first
   // non-visible line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= (h_counter == 10'd0) && (v_counter == V_TICK);
      end
   end

   // Position is only taken at the frame tick so a frame never tears.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         px_q <= 10'd0;
         py_q <= 10'd0;
      end else if (tick_q) begin
         px_q <= POS_X;
         py_q <= POS_Y;
      end
   end

   // Sequencer state register, with busy registered from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= busy_d;
      end
   end

   // Sequencer next-state: stop dominates, start only acts from IDLE.
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHOW;
            ST_SHOW:  if (tick_q && (frame_cnt_q == HOLD_LAST)) state_d = ST_BLINK;
            ST_BLINK: state_d = ST_BLINK;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Sequencer outputs: draw enable for stage 1 and the next busy value.
   always_comb begin
      draw_en = 1'b0;
      busy_d  = (state_d != ST_IDLE);
      case (state_q)
         ST_SHOW:  draw_en = 1'b1;
         ST_BLINK: draw_en = vis_q;
         default:  draw_en = 1'b0;
      endcase
   end

   // Frame, animation and visibility counters; they move only at frame
   // ticks, except for the clear that accompanies an accepted start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt_q <= '0;
         anim_cnt_q  <= '0;
         anim_sel_q  <= 1'b0;
         vis_q       <= 1'b1;
      end else if (stop) begin
         frame_cnt_q <= frame_cnt_q;
      end else if ((state_q == ST_IDLE) && start) begin
         frame_cnt_q <= '0;
         anim_cnt_q  <= '0;
         anim_sel_q  <= 1'b0;
         vis_q       <= 1'b1;
      end else if (tick_q && (state_q != ST_IDLE)) begin
         if (anim_cnt_q == ANIM_LAST) begin
            anim_cnt_q <= '0;
            anim_sel_q <= ~anim_sel_q;
         end else begin
            anim_cnt_q <= anim_cnt_q + AC_W'(1);
         end

         if (state_q == ST_SHOW) begin
            if (frame_cnt_q == HOLD_LAST) begin
               frame_cnt_q <= '0;
            end else begin
               frame_cnt_q <= frame_cnt_q + FC_W'(1);
            end
         end else begin
            if (frame_cnt_q == BLINK_LAST) begin
               frame_cnt_q <= '0;
               vis_q       <= ~vis_q;
            end else begin
               frame_cnt_q <= frame_cnt_q + FC_W'(1);
            end
         end
      end
   end

   // Stage 1 window test: offsets are zero-extended to 11 bits and the
   // explicit >= checks reject pixels left of / above the sprite.
   always_comb begin
      dx     = {1'b0, h_counter} - {1'b0, px_q};
      dy     = {1'b0, v_counter} - {1'b0, py_q};
      in_box = (h_counter >= px_q) && (dx < BOX_W) &&
               (v_counter >= py_q) && (dy < BOX_H);
   end

   // Stage 1 register: hit already includes the draw enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_hit_q <= 1'b0;
         s1_dx_q  <= 11'd0;
         s1_dy_q  <= 11'd0;
      end else begin
         s1_hit_q <= in_box && draw_en;
         s1_dx_q  <= dx;
         s1_dy_q  <= dy;
      end
   end

   // Stage 2 lookup: constant division back to source pixels, then the
   // bit of the currently selected animation frame.
   always_comb begin
      sx      = s1_dx_q / SCALE_V;
      sy      = s1_dy_q / SCALE_V;
      pix_idx = IDX_W'(sy) * IDX_W'(SPR_W) + IDX_W'(sx);
      pattern = anim_sel_q ? PATTERN_B : PATTERN_A;
      lit     = s1_hit_q && pattern[pix_idx];
   end

   // Stage 2 register: colour out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         R <= 8'd0;
         G <= 8'd0;
         B <= 8'd0;
      end else begin
         R <= lit ? COLOR[23:16] : 8'd0;
         G <= lit ? COLOR[15:8]  : 8'd0;
         B <= lit ? COLOR[7:0]   : 8'd0;
      end
   end

endmodule

// File: tb/tb_sprite_anim_render.sv
// tb_sprite_anim_render
// Directed bench: scan counters are driven directly so a "frame" is just a
// one-cycle visit to (0, V_ACTIVE). Expected colours are hand-derived from
// the pattern geometry: pattern A lights source row 5, pattern B row 2,
// SCALE 6, so with py=50 A covers y 80..85 and B covers y 62..67.

module tb_sprite_anim_render;

   localparam logic [120:0] PAT_A = {55'd0, 11'h7FF, 55'd0};
   localparam logic [120:0] PAT_B = {88'd0, 11'h7FF, 22'd0};
   localparam logic [23:0]  LIT   = 24'hFFFFFF;
   localparam logic [23:0]  DARK  = 24'h000000;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [23:0] rgb;
   } pix_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] h_counter;
   logic [9:0] v_counter;
   logic [9:0] pos_x;
   logic [9:0] pos_y;
   logic       start;
   logic       stop;
   logic [7:0] r;
   logic [7:0] g;
   logic [7:0] b;
   logic       busy;
   logic [1:0] state_dbg;

   int n_vec = 0;
   int n_err = 0;

   sprite_anim_render #(
      .SCALE        (6),
      .SPR_W        (11),
      .SPR_H        (11),
      .PATTERN_A    (PAT_A),
      .PATTERN_B    (PAT_B),
      .COLOR        (LIT),
      .V_ACTIVE     (480),
      .ANIM_FRAMES  (2),
      .HOLD_FRAMES  (4),
      .BLINK_FRAMES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .h_counter (h_counter),
      .v_counter (v_counter),
      .POS_X     (pos_x),
      .POS_Y     (pos_y),
      .start     (start),
      .stop      (stop),
      .R         (r),
      .G         (g),
      .B         (b),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // Global time bound
   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, %0d vectors applied", n_vec);
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   task automatic park();
      h_counter = 10'd0;
      v_counter = 10'd1000;
   endtask

   task automatic frame_tick();
      h_counter = 10'd0;
      v_counter = 10'd480;
      @(posedge clk); #1;
      park();
      @(posedge clk); #1;
   endtask

   task automatic pulse(input logic s_start, input logic s_stop);
      start = s_start;
      stop  = s_stop;
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic sample_pixel(input logic [9:0] x, input logic [9:0] y,
                               output logic [23:0] rgb);
      h_counter = x;
      v_counter = y;
      @(posedge clk); #1;
      park();
      @(posedge clk); #1;
      rgb = {r, g, b};
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [23:0] got;
      reset = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      pos_x = 10'd100;
      pos_y = 10'd50;
      park();
      @(posedge clk); @(posedge clk); #1;
      n_vec++;
      if ({r, g, b} !== DARK) begin
         n_err++; $display("FAIL reset_rgb: got %06h expected %06h", {r, g, b}, DARK);
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL reset_busy: got %b expected 0", busy);
      end
      n_vec++;
      if (state_dbg !== 2'd0) begin
         n_err++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      frame_tick();
      sample_pixel(10'd100, 10'd80, got);
      n_vec++;
      if (got !== DARK) begin
         n_err++; $display("FAIL reset_nodraw: got %06h expected %06h", got, DARK);
      end
   endtask

   task automatic test_basic_draw();
      logic [23:0] got;
      pix_t v [7];
      v = '{'{10'd165, 10'd85, LIT},  '{10'd130, 10'd82, LIT},
            '{10'd100, 10'd85, LIT},  '{10'd100, 10'd79, DARK},
            '{10'd166, 10'd80, DARK}, '{10'd99,  10'd80, DARK},
            '{10'd100, 10'd86, DARK}};
      pulse(1'b1, 1'b0);
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL basic_busy_rise: got %b expected 1", busy);
      end
      frame_tick();
      // Latency: nothing after one clock, colour after two.
      h_counter = 10'd100;
      v_counter = 10'd80;
      @(posedge clk); #1;
      park();
      n_vec++;
      if ({r, g, b} !== DARK) begin
         n_err++; $display("FAIL basic_latency1: got %06h expected %06h", {r, g, b}, DARK);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({r, g, b} !== LIT) begin
         n_err++; $display("FAIL basic_latency2: got %06h expected %06h", {r, g, b}, LIT);
      end
      foreach (v[i]) begin
         sample_pixel(v[i].x, v[i].y, got);
         n_vec++;
         if (got !== v[i].rgb) begin
            n_err++;
            $display("FAIL basic_draw (%0d,%0d): got %06h expected %06h",
                     v[i].x, v[i].y, got, v[i].rgb);
         end
      end
   endtask

   task automatic test_tear_free();
      logic [23:0] got;
      pix_t v [6];
      // Mid-frame move: the current frame keeps x=100.
      pos_x = 10'd200;
      sample_pixel(10'd100, 10'd80, got);
      n_vec++;
      if (got !== LIT) begin
         n_err++; $display("FAIL tear_old_pos: got %06h expected %06h", got, LIT);
      end
      sample_pixel(10'd200, 10'd80, got);
      n_vec++;
      if (got !== DARK) begin
         n_err++; $display("FAIL tear_new_early: got %06h expected %06h", got, DARK);
      end
      // Second tick: new position, and animation swaps to pattern B.
      frame_tick();
      v = '{'{10'd200, 10'd62, LIT},  '{10'd265, 10'd67, LIT},
            '{10'd266, 10'd67, DARK}, '{10'd100, 10'd62, DARK},
            '{10'd200, 10'd80, DARK}, '{10'd199, 10'd62, DARK}};
      foreach (v[i]) begin
         sample_pixel(v[i].x, v[i].y, got);
         n_vec++;
         if (got !== v[i].rgb) begin
            n_err++;
            $display("FAIL tear_next_frame (%0d,%0d): got %06h expected %06h",
                     v[i].x, v[i].y, got, v[i].rgb);
         end
      end
   endtask

   task automatic test_anim_sequence();
      logic [23:0] got;
      // Per tick 3..8: {A row lit, B row lit, state}
      logic [1:0] exp_a  [6];
      logic [1:0] exp_st [6];
      logic       ea;
      logic       eb;
      exp_a  = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10};
      exp_st = '{2'd1,  2'd2,  2'd2,  2'd2,  2'd2,  2'd2};
      // start while SHOW must not restart the hold count or animation
      pulse(1'b1, 1'b0);
      for (int t = 0; t < 6; t++) begin
         frame_tick();
         ea = exp_a[t][1];
         eb = exp_a[t][0];
         n_vec++;
         if (state_dbg !== exp_st[t]) begin
            n_err++; $display("FAIL anim_state tick%0d: got %0d expected %0d",
                              t + 3, state_dbg, exp_st[t]);
         end
         sample_pixel(10'd200, 10'd80, got);
         n_vec++;
         if (got !== (ea ? LIT : DARK)) begin
            n_err++; $display("FAIL anim_pattern_a tick%0d: got %06h expected %06h",
                              t + 3, got, ea ? LIT : DARK);
         end
         sample_pixel(10'd200, 10'd62, got);
         n_vec++;
         if (got !== (eb ? LIT : DARK)) begin
            n_err++; $display("FAIL anim_pattern_b tick%0d: got %06h expected %06h",
                              t + 3, got, eb ? LIT : DARK);
         end
      end
   endtask

   task automatic test_reset_mid_blink();
      logic [23:0] got;
      h_counter = 10'd200;
      v_counter = 10'd80;
      @(posedge clk); @(posedge clk); #1;
      n_vec++;
      if ({r, g, b} !== LIT) begin
         n_err++; $display("FAIL rst_pre_lit: got %06h expected %06h", {r, g, b}, LIT);
      end
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if ({r, g, b} !== DARK) begin
         n_err++; $display("FAIL rst_async_rgb: got %06h expected %06h", {r, g, b}, DARK);
      end
      n_vec++;
      if (busy !== 1'b0 || state_dbg !== 2'd0) begin
         n_err++; $display("FAIL rst_async_state: got busy=%b state=%0d expected busy=0 state=0",
                           busy, state_dbg);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      park();
      @(posedge clk); #1;
      frame_tick();
      sample_pixel(10'd200, 10'd80, got);
      n_vec++;
      if (got !== DARK || busy !== 1'b0) begin
         n_err++; $display("FAIL rst_no_start: got rgb=%06h busy=%b expected rgb=000000 busy=0",
                           got, busy);
      end
   endtask

   task automatic test_start_stop();
      logic [23:0] exp_rgb;
      pulse(1'b1, 1'b1);
      n_vec++;
      if (busy !== 1'b0 || state_dbg !== 2'd0) begin
         n_err++; $display("FAIL startstop_same: got busy=%b state=%0d expected busy=0 state=0",
                           busy, state_dbg);
      end
      pulse(1'b1, 1'b0);
      frame_tick();
      // Scan along line 80 from x=200; stop in cycle 2.
      for (int i = 0; i < 7; i++) begin
         if (i >= 2) begin
            exp_rgb = (i <= 4) ? LIT : DARK;
            n_vec++;
            if ({r, g, b} !== exp_rgb) begin
               n_err++; $display("FAIL stop_mid_line cycle%0d: got %06h expected %06h",
                                 i, {r, g, b}, exp_rgb);
            end
         end
         if (i == 3) begin
            n_vec++;
            if (busy !== 1'b0) begin
               n_err++; $display("FAIL stop_busy_fall: got %b expected 0", busy);
            end
         end
         h_counter = 10'd200 + 10'(i);
         v_counter = 10'd80;
         stop      = (i == 2);
         @(posedge clk); #1;
      end
      stop = 1'b0;
      park();
   endtask

   task automatic test_clipping();
      logic [23:0] got;
      pix_t v [7];
      v = '{'{10'd1000, 10'd500, LIT},  '{10'd1023, 10'd505, LIT},
            '{10'd1010, 10'd499, DARK}, '{10'd1010, 10'd506, DARK},
            '{10'd0,    10'd500, DARK}, '{10'd41,   10'd500, DARK},
            '{10'd999,  10'd500, DARK}};
      pos_x = 10'd1000;
      pos_y = 10'd470;
      pulse(1'b1, 1'b0);
      frame_tick();
      foreach (v[i]) begin
         sample_pixel(v[i].x, v[i].y, got);
         n_vec++;
         if (got !== v[i].rgb) begin
            n_err++;
            $display("FAIL clipping (%0d,%0d): got %06h expected %06h",
                     v[i].x, v[i].y, got, v[i].rgb);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic_draw();
      test_tear_free();
      test_anim_sequence();
      test_reset_mid_blink();
      test_start_stop();
      test_clipping();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
